mvau_weight_mem_multi: RTL and testbench

Runtime-loadable, multi-PE weight memory for the MVAU datapath. It holds `PE` banks of `WMEM_DEPTH` words, each `SIMD*TW` bits wide. Banks are filled from a streaming load port and then read in parallel, one address for all banks, by the MVAU control unit. It generalises the single-bank, file-initialised weight memory with the following additions:
- PE channel count
- a load FSM with valid/ready handshake
- reload
- a read-valid pipeline with an optional output register

---
 rtl/mvau_weight_mem_multi.sv | 140 ++++++++++++++
 tb/tb_mvau_weight_mem_multi.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mvau_weight_mem_multi.sv
// Multi-PE weight memory for the MVAU datapath.
// PE banks of WMEM_DEPTH words (SIMD*TW bits each). The banks are filled through
// a valid/ready load stream and can be reloaded later. Once loaded, all banks
// are read in parallel at one shared address, with an optional output register.
module mvau_weight_mem_multi #(
  parameter int PE           = 2,
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 2,
  parameter int OREG         = 0
) (
  input  logic                      aclk,
  input  logic                      rst,
  input  logic [SIMD*TW-1:0]        wload_tdata,
  input  logic                      wload_tvalid,
  output logic                      wload_tready,
  input  logic                      wload_reload,
  output logic                      wmem_loaded,
  input  logic                      wmem_rd_en,
  input  logic [WMEM_ADDR_BW-1:0]   wmem_addr,
  output logic [PE*SIMD*TW-1:0]     wmem_out,
  output logic                      wmem_valid
);

  localparam int WW      = SIMD * TW;
  localparam int BANK_BW = (PE > 1) ? $clog2(PE) : 1;
  localparam logic [BANK_BW-1:0]      LAST_BANK = BANK_BW'(PE - 1);
  localparam logic [WMEM_ADDR_BW-1:0] LAST_WORD = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

  typedef enum logic {ST_LOAD, ST_READY} state_t;

  state_t                  state;
  logic [BANK_BW-1:0]      bank_cnt;
  logic [WMEM_ADDR_BW-1:0] word_cnt;
  logic                    load_fire;
  logic                    rd_accept;
  logic                    rd_valid_q;
  logic [PE*WW-1:0]        rd_data;

  // wload_tready is high only in LOAD, so a handshake implies the LOAD state.
  assign load_fire = wload_tvalid && wload_tready;
  // Reads are honoured only once loaded, and never alongside an accepted reload.
  assign rd_accept = wmem_rd_en && (state == ST_READY) && !wload_reload;

  // Load FSM: walks banks fastest, then words; reload restarts from word 0.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, regardless of the order of the always blocks.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state        <= ST_LOAD;
      bank_cnt     <= '0;
      word_cnt     <= '0;
      wload_tready <= 1'b1;
      wmem_loaded  <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (load_fire) begin
            if (bank_cnt == LAST_BANK) begin
              bank_cnt <= '0;
              if (word_cnt == LAST_WORD) begin
                word_cnt     <= '0;
                state        <= ST_READY;
                wload_tready <= 1'b0;
                wmem_loaded  <= 1'b1;
              end else begin
                word_cnt <= word_cnt + 1'b1;
              end
            end else begin
              bank_cnt <= bank_cnt + 1'b1;
            end
          end
        end
        ST_READY: begin
          if (wload_reload) begin
            state        <= ST_LOAD;
            bank_cnt     <= '0;
            word_cnt     <= '0;
            wload_tready <= 1'b1;
            wmem_loaded  <= 1'b0;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  for (genvar p = 0; p < PE; p++) begin : g_bank
    logic [WW-1:0] mem [WMEM_DEPTH];
    logic [WW-1:0] rd_q;
    logic          we;

    assign we = load_fire && (bank_cnt == BANK_BW'(p));

    // Bank write port: the beat lands at the accepting edge.
    // NOTE: the memory array has no reset so it can map onto block or distributed RAM;
    // readers are held off by wmem_loaded until every word has been written.
    always_ff @(posedge aclk) begin
      if (we) mem[word_cnt] <= wload_tdata;
    end

    // Synchronous read register; it holds its value between accepted reads.
    always_ff @(posedge aclk or posedge rst) begin
      if (rst)            rd_q <= '0;
      else if (rd_accept) rd_q <= mem[wmem_addr];
    end

    assign rd_data[p*WW +: WW] = rd_q;
  end

  // Read-valid stage, aligned with the bank read registers.
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) rd_valid_q <= 1'b0;
    else     rd_valid_q <= rd_accept;
  end

  if (OREG != 0) begin : g_oreg
    logic [PE*WW-1:0] out_q;
    logic             out_valid_q;

    // Optional output register: captures only valid read data, otherwise holds.
    always_ff @(posedge aclk or posedge rst) begin
      if (rst) begin
        out_q       <= '0;
        out_valid_q <= 1'b0;
      end else begin
        out_valid_q <= rd_valid_q;
        if (rd_valid_q) out_q <= rd_data;
      end
    end

    assign wmem_out   = out_q;
    assign wmem_valid = out_valid_q;
  end else begin : g_no_oreg
    assign wmem_out   = rd_data;
    assign wmem_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_mvau_weight_mem_multi.sv
// Directed bench for mvau_weight_mem_multi. Two instances share the same stimulus:
// dut0 has no output register (latency 1), and dut1 has OREG=1 (latency 2).
module tb_mvau_weight_mem_multi;

  localparam int PE = 2, SIMD = 2, TW = 4, DEPTH = 4, ABW = 2;

  logic                  aclk;
  logic                  rst;
  logic [SIMD*TW-1:0]    tdata;
  logic                  tvalid;
  logic                  reload;
  logic                  rd_en;
  logic [ABW-1:0]        addr;
  logic                  tready0, loaded0, valid0;
  logic                  tready1, loaded1, valid1;
  logic [PE*SIMD*TW-1:0] out0, out1;

  int n_cmp = 0;
  int n_err = 0;

  mvau_weight_mem_multi #(
    .PE(PE), .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(ABW), .OREG(0)
  ) dut0 (
    .aclk(aclk), .rst(rst), .wload_tdata(tdata), .wload_tvalid(tvalid),
    .wload_tready(tready0), .wload_reload(reload), .wmem_loaded(loaded0),
    .wmem_rd_en(rd_en), .wmem_addr(addr), .wmem_out(out0), .wmem_valid(valid0)
  );

  mvau_weight_mem_multi #(
    .PE(PE), .SIMD(SIMD), .TW(TW), .WMEM_DEPTH(DEPTH), .WMEM_ADDR_BW(ABW), .OREG(1)
  ) dut1 (
    .aclk(aclk), .rst(rst), .wload_tdata(tdata), .wload_tvalid(tvalid),
    .wload_tready(tready1), .wload_reload(reload), .wmem_loaded(loaded1),
    .wmem_rd_en(rd_en), .wmem_addr(addr), .wmem_out(out1), .wmem_valid(valid1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Expected word at address a when beats base, base+1, ... were loaded:
  // bank0 holds beat 2a, bank1 holds beat 2a+1.
  function automatic logic [15:0] exp_word(input logic [7:0] base, input int a);
    logic [7:0] lo, hi;
    lo = base + 8'(2 * a);
    hi = base + 8'(2 * a + 1);
    return {hi, lo};
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset(input string tag);
    tvalid = 1'b0; reload = 1'b0; rd_en = 1'b0; addr = '0; tdata = '0;
    @(posedge aclk);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (tready0 !== 1'b1) begin n_err++; $display("FAIL %s tready0: got %b want 1", tag, tready0); end
    n_cmp++; if (loaded0 !== 1'b0) begin n_err++; $display("FAIL %s loaded0: got %b want 0", tag, loaded0); end
    n_cmp++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL %s valid0: got %b want 0", tag, valid0); end
    n_cmp++; if (out0 !== 16'h0) begin n_err++; $display("FAIL %s out0: got %h want 0000", tag, out0); end
    n_cmp++; if (tready1 !== 1'b1) begin n_err++; $display("FAIL %s tready1: got %b want 1", tag, tready1); end
    n_cmp++; if (loaded1 !== 1'b0) begin n_err++; $display("FAIL %s loaded1: got %b want 0", tag, loaded1); end
    n_cmp++; if (valid1 !== 1'b0) begin n_err++; $display("FAIL %s valid1: got %b want 0", tag, valid1); end
    n_cmp++; if (out1 !== 16'h0) begin n_err++; $display("FAIL %s out1: got %h want 0000", tag, out1); end
    @(posedge aclk);
    #1 rst = 1'b0;
  endtask

  // Load 8 beats base..base+7. With gaps, idle cycles precede each beat.
  // With rd_hold, a read of address 2 is requested for the entire load.
  task automatic load_words(input logic [7:0] base, input bit use_gaps, input bit rd_hold);
    int gaps [8] = '{0, 2, 1, 0, 3, 0, 1, 2};
    rd_en = rd_hold;
    addr  = 2'd2;
    for (int k = 0; k < 8; k++) begin
      if (use_gaps) begin
        for (int g = 0; g < gaps[k]; g++) begin
          tvalid = 1'b0; tdata = 8'hAA;
          tick();
          n_cmp++; if (loaded0 !== 1'b0) begin n_err++; $display("FAIL gap_loaded k=%0d: got %b want 0", k, loaded0); end
          if (rd_hold) begin
            n_cmp++; if (valid0 !== 1'b0 || valid1 !== 1'b0) begin n_err++; $display("FAIL gap_rd_drop k=%0d: got %b%b want 00", k, valid0, valid1); end
          end
        end
      end
      tvalid = 1'b1; tdata = base + 8'(k);
      tick();
      if (k < 7) begin
        n_cmp++; if (loaded0 !== 1'b0 || tready0 !== 1'b1) begin n_err++; $display("FAIL beat_state k=%0d: got loaded=%b tready=%b want 0/1", k, loaded0, tready0); end
      end else begin
        n_cmp++; if (loaded0 !== 1'b1 || tready0 !== 1'b0) begin n_err++; $display("FAIL last_beat dut0: got loaded=%b tready=%b want 1/0", loaded0, tready0); end
        n_cmp++; if (loaded1 !== 1'b1 || tready1 !== 1'b0) begin n_err++; $display("FAIL last_beat dut1: got loaded=%b tready=%b want 1/0", loaded1, tready1); end
      end
      if (rd_hold) begin
        n_cmp++; if (valid0 !== 1'b0 || valid1 !== 1'b0) begin n_err++; $display("FAIL load_rd_drop k=%0d: got %b%b want 00", k, valid0, valid1); end
      end
    end
    tvalid = 1'b0;
    if (rd_hold) begin
      tick();
      n_cmp++; if (valid0 !== 1'b1 || out0 !== exp_word(base, 2)) begin n_err++; $display("FAIL first_rd dut0: got v=%b %h want 1 %h", valid0, out0, exp_word(base, 2)); end
      n_cmp++; if (valid1 !== 1'b0) begin n_err++; $display("FAIL first_rd dut1 early: got %b want 0", valid1); end
      rd_en = 1'b0;
      tick();
      n_cmp++; if (valid1 !== 1'b1 || out1 !== exp_word(base, 2)) begin n_err++; $display("FAIL first_rd dut1: got v=%b %h want 1 %h", valid1, out1, exp_word(base, 2)); end
      n_cmp++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL first_rd dut0 tail: got %b want 0", valid0); end
    end
  endtask

  // Back-to-back reads of addresses 0..3, then two idle cycles to check drain and hold.
  task automatic read_seq(input logic [7:0] base, input string tag);
    for (int i = 0; i < 6; i++) begin
      rd_en = (i < 4);
      addr  = 2'(i);
      tick();
      if (i < 4) begin
        n_cmp++; if (valid0 !== 1'b1 || out0 !== exp_word(base, i)) begin n_err++; $display("FAIL %s dut0 i=%0d: got v=%b %h want 1 %h", tag, i, valid0, out0, exp_word(base, i)); end
      end else begin
        n_cmp++; if (valid0 !== 1'b0 || out0 !== exp_word(base, 3)) begin n_err++; $display("FAIL %s dut0 hold i=%0d: got v=%b %h want 0 %h", tag, i, valid0, out0, exp_word(base, 3)); end
      end
      if (i == 0) begin
        n_cmp++; if (valid1 !== 1'b0) begin n_err++; $display("FAIL %s dut1 latency: got v=%b want 0", tag, valid1); end
      end else if (i <= 4) begin
        n_cmp++; if (valid1 !== 1'b1 || out1 !== exp_word(base, i - 1)) begin n_err++; $display("FAIL %s dut1 i=%0d: got v=%b %h want 1 %h", tag, i, valid1, out1, exp_word(base, i - 1)); end
      end else begin
        n_cmp++; if (valid1 !== 1'b0 || out1 !== exp_word(base, 3)) begin n_err++; $display("FAIL %s dut1 hold: got v=%b %h want 0 %h", tag, valid1, out1, exp_word(base, 3)); end
      end
    end
  endtask

  task automatic test_full_load();
    load_words(8'h10, 1'b0, 1'b0);
    read_seq(8'h10, "full_load");
  endtask

  task automatic test_ignore_tvalid();
    tvalid = 1'b1; tdata = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (tready0 !== 1'b0 || loaded0 !== 1'b1) begin n_err++; $display("FAIL ready_tvalid i=%0d: got tready=%b loaded=%b want 0/1", i, tready0, loaded0); end
    end
    tvalid = 1'b0;
    read_seq(8'h10, "after_extra_tvalid");
  endtask

  task automatic test_reload_same_cycle();
    reload = 1'b1; rd_en = 1'b1; addr = 2'd1;
    tick();
    reload = 1'b0; rd_en = 1'b0;
    n_cmp++; if (loaded0 !== 1'b0 || tready0 !== 1'b1) begin n_err++; $display("FAIL reload_state: got loaded=%b tready=%b want 0/1", loaded0, tready0); end
    n_cmp++; if (valid0 !== 1'b0) begin n_err++; $display("FAIL reload_rd_drop dut0: got %b want 0", valid0); end
    tick();
    n_cmp++; if (valid1 !== 1'b0) begin n_err++; $display("FAIL reload_rd_drop dut1: got %b want 0", valid1); end
    // A reload while already loading has no effect.
    reload = 1'b1;
    tick();
    reload = 1'b0;
    n_cmp++; if (loaded0 !== 1'b0 || tready0 !== 1'b1) begin n_err++; $display("FAIL reload_in_load: got loaded=%b tready=%b want 0/1", loaded0, tready0); end
  endtask

  task automatic test_handshake();
    load_words(8'h10, 1'b1, 1'b1);
    read_seq(8'h10, "handshake");
  endtask

  task automatic test_reload();
    rd_en = 1'b1; addr = 2'd2;
    tick();
    n_cmp++; if (valid0 !== 1'b1 || out0 !== 16'h1514) begin n_err++; $display("FAIL inflight dut0: got v=%b %h want 1 1514", valid0, out0); end
    rd_en = 1'b0; reload = 1'b1;
    tick();
    reload = 1'b0;
    n_cmp++; if (loaded0 !== 1'b0) begin n_err++; $display("FAIL reload_loaded: got %b want 0", loaded0); end
    n_cmp++; if (valid1 !== 1'b1 || out1 !== 16'h1514) begin n_err++; $display("FAIL inflight dut1: got v=%b %h want 1 1514", valid1, out1); end
    load_words(8'h20, 1'b0, 1'b0);
    read_seq(8'h20, "reloaded");
  endtask

  task automatic test_reset_mid_load();
    for (int k = 0; k < 3; k++) begin
      tvalid = 1'b1; tdata = 8'h30 + 8'(k);
      tick();
    end
    test_reset("reset_mid_load");
    load_words(8'h40, 1'b0, 1'b0);
    read_seq(8'h40, "after_reset");
  endtask

  initial begin
    rst = 1'b0; tvalid = 1'b0; tdata = '0; reload = 1'b0; rd_en = 1'b0; addr = '0;
    test_reset("reset_initial");
    test_full_load();
    test_ignore_tvalid();
    test_reload_same_cycle();
    test_handshake();
    test_reload();
    test_reset("reset_mid_op");
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
